// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide scheduler.
package mcycle_pkg;

    localparam int unsigned REG_AW = 4;

    localparam logic MC_OP_MUL = 1'b0;
    localparam logic MC_OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4
    } state_e;

endpackage

// File: rtl/mcycle_scoreboard.sv
// Pending-destination set: bits are set on accept and cleared on final write
// or abort; three lookup ports feed the decode hazard check.
module mcycle_scoreboard
    import mcycle_pkg::*;
#(
    parameter int unsigned NREG = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_a_i,
    input  logic [REG_AW-1:0] set_a_addr_i,
    input  logic              set_b_i,
    input  logic [REG_AW-1:0] set_b_addr_i,
    input  logic              clr_a_i,
    input  logic [REG_AW-1:0] clr_a_addr_i,
    input  logic              clr_b_i,
    input  logic [REG_AW-1:0] clr_b_addr_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic [REG_AW-1:0] ra3_i,
    output logic              hit1_c_o,
    output logic              hit2_c_o,
    output logic              hit3_c_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_a_i) set_mask = set_mask | (NREG'(1) << set_a_addr_i);
        if (set_b_i) set_mask = set_mask | (NREG'(1) << set_b_addr_i);
        if (clr_a_i) clr_mask = clr_mask | (NREG'(1) << clr_a_addr_i);
        if (clr_b_i) clr_mask = clr_mask | (NREG'(1) << clr_b_addr_i);
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign hit1_c_o = pend_q[ra1_i];
    assign hit2_c_o = pend_q[ra2_i];
    assign hit3_c_o = pend_q[ra3_i];

endmodule

// File: rtl/mcycle_scheduler.sv
// Sequences one multiply/divide through the multi-cycle unit, tracks its
// destinations for hazard detection and retires 1-2 words via the shared port.
module mcycle_scheduler
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 2 * WIDTH + 8,
    parameter int unsigned NREG    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_op_i,
    input  logic              req_long_i,
    input  logic              req_add_i,
    input  logic [WIDTH-1:0]  req_opa_i,
    input  logic [WIDTH-1:0]  req_opb_i,
    input  logic [WIDTH-1:0]  req_acc_i,
    input  logic [REG_AW-1:0] req_wa3_i,
    input  logic [REG_AW-1:0] req_wa5_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic [REG_AW-1:0] ra3_i,
    output logic              hazard_c_o,
    output logic              mc_start_c_o,
    output logic              mc_op_o,
    output logic [WIDTH-1:0]  mc_op1_o,
    output logic [WIDTH-1:0]  mc_op2_o,
    input  logic              mc_busy_i,
    input  logic              mc_done_i,
    input  logic [WIDTH-1:0]  mc_res_high_i,
    input  logic [WIDTH-1:0]  mc_res_low_i,
    input  logic              wb_port_busy_i,
    output logic              wb_en_c_o,
    output logic [REG_AW-1:0] wb_addr_o,
    output logic [WIDTH-1:0]  wb_data_o,
    output logic              pending_o,
    output logic              timeout_err_o
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic                op_q, op_d;
    logic                long_q, long_d;
    logic                add_q, add_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [REG_AW-1:0]   wa3_q, wa3_d;
    logic [REG_AW-1:0]   wa5_q, wa5_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tout_q, tout_d;
    logic                ready_q, ready_d;
    logic                pend_q, pend_d;

    logic                set_a, set_b, clr_a, clr_b;
    logic                hit1, hit2, hit3;
    logic [DW-1:0]       sum_c;

    // Unit result plus optional zero-extended accumulator, wrapping at 2*WIDTH
    assign sum_c = {mc_res_high_i, mc_res_low_i}
                 + ((add_q && (op_q == MC_OP_MUL)) ? DW'(acc_q) : '0);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        long_d       = long_q;
        add_d        = add_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        acc_d        = acc_q;
        wa3_d        = wa3_q;
        wa5_d        = wa5_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        tout_d       = 1'b0;
        set_a        = 1'b0;
        set_b        = 1'b0;
        clr_a        = 1'b0;
        clr_b        = 1'b0;
        mc_start_c_o = 1'b0;
        wb_en_c_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d   = req_op_i;
                    long_d = req_long_i;
                    add_d  = req_add_i;
                    opa_d  = req_opa_i;
                    opb_d  = req_opb_i;
                    acc_d  = req_acc_i;
                    wa3_d  = req_wa3_i;
                    wa5_d  = req_wa5_i;
                    set_a  = 1'b1;
                    set_b  = req_long_i;
                    // Divide by zero bypasses the unit with a fixed result
                    if ((req_op_i == MC_OP_DIV) && (req_opb_i == '0)) begin
                        hi_d    = req_opa_i;
                        lo_d    = '1;
                        state_d = S_WB_LO;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!mc_busy_i) begin
                    mc_start_c_o = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mc_done_i) begin
                    hi_d    = sum_c[DW-1:WIDTH];
                    lo_d    = sum_c[WIDTH-1:0];
                    state_d = S_WB_LO;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    clr_a   = 1'b1;
                    clr_b   = long_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB_LO: begin
                if (!wb_port_busy_i) begin
                    wb_en_c_o = 1'b1;
                    if (long_q) begin
                        state_d = S_WB_HI;
                    end else begin
                        clr_a   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WB_HI: begin
                if (!wb_port_busy_i) begin
                    wb_en_c_o = 1'b1;
                    clr_a     = 1'b1;
                    clr_b     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        pend_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            long_q  <= 1'b0;
            add_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            wa3_q   <= '0;
            wa5_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
            ready_q <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            long_q  <= long_d;
            add_q   <= add_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            wa3_q   <= wa3_d;
            wa5_q   <= wa5_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
        end
    end

    mcycle_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_a_i      (set_a),
        .set_a_addr_i (req_wa3_i),
        .set_b_i      (set_b),
        .set_b_addr_i (req_wa5_i),
        .clr_a_i      (clr_a),
        .clr_a_addr_i (wa3_q),
        .clr_b_i      (clr_b),
        .clr_b_addr_i (wa5_q),
        .ra1_i        (ra1_i),
        .ra2_i        (ra2_i),
        .ra3_i        (ra3_i),
        .hit1_c_o     (hit1),
        .hit2_c_o     (hit2),
        .hit3_c_o     (hit3)
    );

    assign hazard_c_o    = hit1 | hit2 | hit3;
    assign req_ready_o   = ready_q;
    assign pending_o     = pend_q;
    assign timeout_err_o = tout_q;
    assign mc_op_o       = op_q;
    assign mc_op1_o      = opa_q;
    assign mc_op2_o      = opb_q;
    assign wb_addr_o     = (state_q == S_WB_HI) ? wa5_q : wa3_q;
    assign wb_data_o     = (state_q == S_WB_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mcycle_scheduler.sv
// Scoreboard bench for mcycle_scheduler with a behavioural multiply/divide unit.
module tb_mcycle_scheduler;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 2 * W + 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_op = 1'b0, req_long = 1'b0, req_add = 1'b0;
    logic [W-1:0]  req_opa = '0, req_opb = '0, req_acc = '0;
    logic [3:0]    req_wa3 = '0, req_wa5 = '0, ra1 = '0, ra2 = '0, ra3 = '0;
    logic          req_ready, hazard, mc_start, mc_op, wb_en, pending, timeout_err;
    logic [W-1:0]  mc_op1, mc_op2, wb_data;
    logic [3:0]    wb_addr;
    logic          mc_busy = 1'b0, mc_done = 1'b0;
    logic [W-1:0]  mc_res_high = '0, mc_res_low = '0;
    logic          wb_port_busy;
    logic          wb_busy_force = 1'b0, wb_busy_rand = 1'b0;
    bit            rand_wb = 1'b0;

    always #5 clk = ~clk;
    assign wb_port_busy = rand_wb ? wb_busy_rand : wb_busy_force;

    mcycle_scheduler dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_long_i(req_long), .req_add_i(req_add),
        .req_opa_i(req_opa), .req_opb_i(req_opb), .req_acc_i(req_acc),
        .req_wa3_i(req_wa3), .req_wa5_i(req_wa5),
        .ra1_i(ra1), .ra2_i(ra2), .ra3_i(ra3),
        .hazard_c_o(hazard), .mc_start_c_o(mc_start), .mc_op_o(mc_op),
        .mc_op1_o(mc_op1), .mc_op2_o(mc_op2),
        .mc_busy_i(mc_busy), .mc_done_i(mc_done),
        .mc_res_high_i(mc_res_high), .mc_res_low_i(mc_res_low),
        .wb_port_busy_i(wb_port_busy), .wb_en_c_o(wb_en),
        .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .pending_o(pending), .timeout_err_o(timeout_err)
    );

    typedef struct {
        bit         is_to;
        logic [3:0] addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    int   unit_lat = 3, recov = 0, start_cnt = 0;
    bit   withhold = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Architectural result: {hi, lo} as the register file should see them
    function automatic logic [63:0] model(input logic op, input logic add,
                                          input logic [W-1:0] a, b, acc);
        if (!op) return 64'(a) * 64'(b) + (add ? 64'(acc) : 64'(0));
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Behavioural multi-cycle unit: fixed latency, optional busy tail
    initial begin
        bit s, o, r;
        logic [W-1:0] a, b;
        logic [63:0] res;
        int cnt, tail;
        cnt = 0; tail = 0; res = '0;
        forever begin
            @(negedge clk);
            s = mc_start; o = mc_op; a = mc_op1; b = mc_op2; r = rst;
            @(posedge clk); #1;
            mc_done = 1'b0;
            if (r) begin
                cnt = 0; tail = 0; mc_busy = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (!withhold) begin
                            mc_done = 1'b1;
                            mc_res_high = res[63:32];
                            mc_res_low  = res[31:0];
                        end
                        tail = recov;
                        mc_busy = (tail > 0);
                    end
                end else if (tail > 0) begin
                    tail--;
                    mc_busy = (tail > 0);
                end
                if (s) begin
                    res = o ? {a % b, a / b} : 64'(a) * 64'(b);
                    cnt = unit_lat - 1;
                    mc_busy = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 wb_busy_rand = ($urandom_range(0, 2) == 0);
    end

    // Monitor: every write or abort must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (mc_start) begin
                start_cnt++;
                chk("start_while_busy", 64'(mc_busy), 64'(0));
            end
            if (wb_en || timeout_err) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event wb_en=%0b timeout=%0b addr=%0d data=0x%0h required=none",
                             wb_en, timeout_err, wb_addr, wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", 64'(timeout_err), 64'(mon_e.is_to));
                    if (!mon_e.is_to) begin
                        chk("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
                        chk("wb_data", 64'(wb_data), 64'(mon_e.data));
                    end
                end
            end
        end
    end

    // mode 0: expect writes, 1: expect abort, 2: expect nothing
    task automatic issue_req(input logic op, lng, add, input logic [W-1:0] a, b, acc,
                             input logic [3:0] wa3, wa5, input int mode);
        logic [63:0] full;
        exp_t e;
        bit ok;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_long = lng; req_add = add;
        req_opa = a; req_opb = b; req_acc = acc; req_wa3 = wa3; req_wa5 = wa5;
        if (mode == 0) begin
            full = model(op, add, a, b, acc);
            e.is_to = 1'b0; e.addr = wa3; e.data = full[31:0];
            exp_q.push_back(e);
            if (lng) begin
                e.addr = wa5; e.data = full[63:32];
                exp_q.push_back(e);
            end
        end else if (mode == 1) begin
            e.is_to = 1'b1; e.addr = '0; e.data = '0;
            exp_q.push_back(e);
        end
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !pending) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t0;
        bit found;
        logic op, lng, add;
        logic [W-1:0] a, b, acc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_hazard", 64'(hazard), 64'(0));
        chk("rst_start", 64'(mc_start), 64'(0));
        chk("rst_wb_en", 64'(wb_en), 64'(0));
        chk("rst_wb_data", 64'(wb_data), 64'(0));
        chk("rst_timeout", 64'(timeout_err), 64'(0));
        chk("rst_op1", 64'(mc_op1), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // MUL 7*6 -> r2, hazard on r2 through the write, latency 2+L
        ra1 = 4'd2;
        issue_req(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 4'd2, 4'd0, 0);
        found = 1'b0;
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            chk("hazard_inflight", 64'(hazard), 64'(1));
            if (wb_en) begin
                chk("mul_latency", 64'(k), 64'(2 + unit_lat));
                found = 1'b1;
                break;
            end
        end
        chk("mul_written", 64'(found), 64'(1));
        @(negedge clk);
        chk("hazard_cleared", 64'(hazard), 64'(0));
        drain();

        // Long MUL: two writes on consecutive cycles
        issue_req(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd1, 4'd4, 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wb_en) break;
        end
        @(negedge clk);
        chk("long_second_write", 64'(wb_en), 64'(1));
        chk("long_second_addr", 64'(wb_addr), 64'(4));
        drain();

        // MLA with the write port stolen for three cycles
        wb_busy_force = 1'b1;
        issue_req(1'b0, 1'b0, 1'b1, 32'd3, 32'd5, 32'd10, 4'd7, 4'd0, 0);
        for (int k = 1; k <= 5 + unit_lat; k++) begin
            @(negedge clk);
            if (k >= 2 + unit_lat && k <= 4 + unit_lat) begin
                chk("stall_no_wb", 64'(wb_en), 64'(0));
                chk("stall_data", 64'(wb_data), 64'(25));
            end
            if (k == 5 + unit_lat) begin
                chk("stall_release_wb", 64'(wb_en), 64'(1));
                chk("stall_release_data", 64'(wb_data), 64'(25));
            end
            if (k == 4 + unit_lat) begin
                @(posedge clk); #1 wb_busy_force = 1'b0;
            end
        end
        drain();

        // Long DIV 100/7 and long DIV by zero
        issue_req(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, 32'd0, 4'd3, 4'd6, 0);
        drain();
        t0 = start_cnt;
        issue_req(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 4'd8, 4'd9, 0);
        drain();
        chk("div0_no_start", 64'(start_cnt - t0), 64'(0));

        // Second request held off until the first retires
        issue_req(1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 4'd10, 4'd0, 0);
        fork
            issue_req(1'b1, 1'b0, 1'b0, 32'd50, 32'd5, 32'd0, 4'd11, 4'd0, 0);
            for (int k = 1; k <= 3 + unit_lat; k++) begin
                @(negedge clk);
                chk("ready_while_busy", 64'(req_ready), 64'(k == 3 + unit_lat));
            end
        join
        drain();

        // Reset while waiting on the unit abandons the op
        unit_lat = 20;
        ra1 = 4'd5;
        issue_req(1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 4'd5, 4'd0, 2);
        repeat (6) @(negedge clk);
        chk("pre_reset_hazard", 64'(hazard), 64'(1));
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("mid_rst_pending", 64'(pending), 64'(0));
        chk("mid_rst_hazard", 64'(hazard), 64'(0));
        chk("mid_rst_wb_en", 64'(wb_en), 64'(0));
        chk("mid_rst_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1 rst = 1'b0;
        unit_lat = 3;
        repeat (30) @(negedge clk);
        chk("post_rst_idle", 64'(pending), 64'(0));

        // Watchdog: unit never reports done
        withhold = 1'b1;
        ra1 = 4'd12;
        issue_req(1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 4'd12, 4'd0, 1);
        t0 = 0; found = 1'b0;
        for (int k = 1; k < int'(TO) + 50; k++) begin
            @(negedge clk);
            if (mc_start) t0 = k;
            if (timeout_err) begin
                chk("timeout_cycles", 64'(k - t0), 64'(TO + 1));
                chk("timeout_hazard", 64'(hazard), 64'(0));
                found = 1'b1;
                break;
            end
        end
        chk("timeout_seen", 64'(found), 64'(1));
        withhold = 1'b0;
        drain();

        // Randomized traffic with random write-port contention and unit latency
        rand_wb = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op  = 1'($urandom_range(0, 1));
            lng = 1'($urandom_range(0, 1));
            add = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (op && $urandom_range(0, 5) == 0) b = '0;
            acc = $urandom;
            unit_lat = int'($urandom_range(2, 6));
            recov    = int'($urandom_range(0, 3));
            issue_req(op, lng, add, a, b, acc, 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 0);
        end
        drain();
        rand_wb = 1'b0;

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
